// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction/strobe bundle between control_unit and its datapath
interface control_unit_if;
   logic       start;
   logic [7:0] instr_data;
   logic       zero_flag;
   logic       pc_enable;
   logic       pc_load;
   logic [3:0] pc_load_addr;
   logic [7:0] ir;
   logic [1:0] alu_op;
   logic       reg_we;
   logic       halted;
   logic [7:0] retired;

   modport master (
      input  start, instr_data, zero_flag,
      output pc_enable, pc_load, pc_load_addr, ir, alu_op, reg_we, halted, retired
   );

   modport slave (
      output start, instr_data, zero_flag,
      input  pc_enable, pc_load, pc_load_addr, ir, alu_op, reg_we, halted, retired
   );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer for a 4-bit-PC accumulator CPU
// Strobes are Moore outputs of state and ir, so an async reset drops them at once.
module control_unit #(
   parameter int OPW = 4
) (
   input logic          clk,
   input logic          rst,
   control_unit_if.master cu
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      HALT    = 3'd4
   } state_t;

   localparam logic [OPW-1:0] OP_LDI = OPW'(1);
   localparam logic [OPW-1:0] OP_ADD = OPW'(2);
   localparam logic [OPW-1:0] OP_SUB = OPW'(3);
   localparam logic [OPW-1:0] OP_JMP = OPW'(4);
   localparam logic [OPW-1:0] OP_JZ  = OPW'(5);
   localparam logic [OPW-1:0] OP_HLT = {OPW{1'b1}};

   state_t         state;
   state_t         state_nxt;
   logic [7:0]     ir_q;
   logic [7:0]     retired_q;
   logic [OPW-1:0] opcode;
   logic           pc_enable_c;
   logic           pc_load_c;
   logic           reg_we_c;
   logic [1:0]     alu_op_c;

   assign opcode = ir_q[7 -: OPW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_q <= 8'h00;
      end else if (state == FETCH) begin
         ir_q <= cu.instr_data;
      end
   end

   // A halting instruction retires on its way into HALT since it never executes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_q <= 8'h00;
      end else if (state == EXECUTE || (state == DECODE && opcode == OP_HLT)) begin
         retired_q <= retired_q + 8'd1;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_enable_c = 1'b0;
      pc_load_c   = 1'b0;
      reg_we_c    = 1'b0;
      alu_op_c    = 2'b00;
      case (state)
         IDLE: begin
            if (cu.start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            state_nxt = DECODE;
         end
         DECODE: begin
            state_nxt = (opcode == OP_HLT) ? HALT : EXECUTE;
         end
         EXECUTE: begin
            state_nxt = FETCH;
            case (opcode)
               OP_LDI: begin
                  reg_we_c    = 1'b1;
                  alu_op_c    = 2'b00;
                  pc_enable_c = 1'b1;
               end
               OP_ADD: begin
                  reg_we_c    = 1'b1;
                  alu_op_c    = 2'b01;
                  pc_enable_c = 1'b1;
               end
               OP_SUB: begin
                  reg_we_c    = 1'b1;
                  alu_op_c    = 2'b10;
                  pc_enable_c = 1'b1;
               end
               OP_JMP: begin
                  pc_load_c = 1'b1;
               end
               OP_JZ: begin
                  pc_load_c   = cu.zero_flag;
                  pc_enable_c = ~cu.zero_flag;
               end
               default: begin
                  pc_enable_c = 1'b1;
               end
            endcase
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign cu.pc_enable    = pc_enable_c;
   assign cu.pc_load      = pc_load_c;
   assign cu.reg_we       = reg_we_c;
   assign cu.alu_op       = alu_op_c;
   assign cu.pc_load_addr = ir_q[3:0];
   assign cu.ir           = ir_q;
   assign cu.halted       = (state == HALT);
   assign cu.retired      = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
`timescale 1ns/1ps
module tb_control_unit;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   control_unit_if bus();

   control_unit #(.OPW(4)) dut (
      .clk (clk),
      .rst (rst),
      .cu  (bus)
   );

   // {pc_enable, pc_load, reg_we, alu_op}
   logic [4:0] strb;
   assign strb = {bus.pc_enable, bus.pc_load, bus.reg_we, bus.alu_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in FETCH with start still high.
   task automatic begin_prog();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      bus.start = 1'b1;
      step();
   endtask

   // From FETCH, presents ins and advances to its EXECUTE cycle.
   task automatic exec_to(input logic [7:0] ins);
      bus.instr_data = ins;
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.instr_data = 8'h13;
      bus.zero_flag = 1'b0;
      #2;
      total++;
      if (strb !== 5'b00000) begin bad++; $display("FAIL reset_strobes got=%b exp=00000", strb); end
      total++;
      if (bus.ir !== 8'h00) begin bad++; $display("FAIL reset_ir got=%h exp=00", bus.ir); end
      total++;
      if (bus.retired !== 8'h00) begin bad++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
      total++;
      if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      total++;
      if (bus.ir !== 8'h00 || strb !== 5'b00000) begin
         bad++; $display("FAIL idle_wait ir=%h strb=%b exp ir=00 strb=00000", bus.ir, strb);
      end
   endtask

   task automatic test_ldi();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      bus.start = 1'b1;
      bus.instr_data = 8'h13;
      step();
      total++;
      if (strb !== 5'b00000) begin bad++; $display("FAIL ldi_fetch_strb got=%b exp=00000", strb); end
      step();
      total++;
      if (bus.ir !== 8'h13) begin bad++; $display("FAIL ldi_ir got=%h exp=13", bus.ir); end
      total++;
      if (strb !== 5'b00000) begin bad++; $display("FAIL ldi_decode_strb got=%b exp=00000", strb); end
      bus.start = 1'b0;
      step();
      total++;
      if (strb !== 5'b10100) begin bad++; $display("FAIL ldi_exec_strb got=%b exp=10100", strb); end
      total++;
      if (bus.pc_load_addr !== 4'h3) begin bad++; $display("FAIL ldi_addr got=%h exp=3", bus.pc_load_addr); end
      bus.instr_data = 8'h00;
      step();
      total++;
      if (strb !== 5'b00000) begin bad++; $display("FAIL ldi_one_cycle got=%b exp=00000", strb); end
      total++;
      if (bus.retired !== 8'd1) begin bad++; $display("FAIL ldi_retired got=%0d exp=1", bus.retired); end
      // third edge after FETCH entry re-entered FETCH; the next edge captures the new word
      step();
      total++;
      if (bus.ir !== 8'h00) begin bad++; $display("FAIL ldi_latency_ir got=%h exp=00", bus.ir); end
      step();
      total++;
      if (strb !== 5'b10000) begin bad++; $display("FAIL nop_exec_strb got=%b exp=10000", strb); end
   endtask

   task automatic test_alu();
      begin_prog();
      exec_to(8'h25);
      total++;
      if (strb !== 5'b10101) begin bad++; $display("FAIL add_strb got=%b exp=10101", strb); end
      step();
      exec_to(8'h36);
      total++;
      if (strb !== 5'b10110) begin bad++; $display("FAIL sub_strb got=%b exp=10110", strb); end
      step();
      total++;
      if (bus.retired !== 8'd2) begin bad++; $display("FAIL alu_retired got=%0d exp=2", bus.retired); end
   endtask

   task automatic test_jump();
      begin_prog();
      exec_to(8'h4A);
      total++;
      if (strb !== 5'b01000) begin bad++; $display("FAIL jmp_strb got=%b exp=01000", strb); end
      total++;
      if (bus.pc_load_addr !== 4'hA) begin bad++; $display("FAIL jmp_addr got=%h exp=a", bus.pc_load_addr); end
      step();
      bus.zero_flag = 1'b1;
      exec_to(8'h57);
      total++;
      if (strb !== 5'b01000) begin bad++; $display("FAIL jz_taken_strb got=%b exp=01000", strb); end
      total++;
      if (bus.pc_load_addr !== 4'h7) begin bad++; $display("FAIL jz_addr got=%h exp=7", bus.pc_load_addr); end
      step();
      bus.zero_flag = 1'b0;
      exec_to(8'h57);
      total++;
      if (strb !== 5'b10000) begin bad++; $display("FAIL jz_not_taken_strb got=%b exp=10000", strb); end
      step();
   endtask

   task automatic test_nop_range();
      logic [7:0] ins;
      begin_prog();
      for (int op = 6; op <= 14; op++) begin
         ins = {op[3:0], 4'h5};
         exec_to(ins);
         total++;
         if (strb !== 5'b10000) begin bad++; $display("FAIL nop_op%0h_strb got=%b exp=10000", op, strb); end
         step();
      end
   endtask

   task automatic test_halt();
      begin_prog();
      bus.instr_data = 8'hF0;
      step();
      total++;
      if (strb !== 5'b00000 || bus.halted !== 1'b0) begin
         bad++; $display("FAIL halt_decode strb=%b halted=%b exp 00000/0", strb, bus.halted);
      end
      bus.instr_data = 8'h13;
      step();
      total++;
      if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_entered got=%b exp=1", bus.halted); end
      total++;
      if (bus.retired !== 8'd1) begin bad++; $display("FAIL halt_retired got=%0d exp=1", bus.retired); end
      for (int i = 0; i < 6; i++) begin
         bus.start = i[0];
         step();
      end
      total++;
      if (bus.halted !== 1'b1 || strb !== 5'b00000) begin
         bad++; $display("FAIL halt_sticky halted=%b strb=%b exp 1/00000", bus.halted, strb);
      end
      total++;
      if (bus.ir !== 8'hF0 || bus.retired !== 8'd1) begin
         bad++; $display("FAIL halt_frozen ir=%h retired=%0d exp f0/1", bus.ir, bus.retired);
      end
   endtask

   task automatic test_wrap();
      begin_prog();
      for (int i = 0; i < 255; i++) begin
         exec_to(8'h00);
         step();
      end
      total++;
      if (bus.retired !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", bus.retired); end
      exec_to(8'h00);
      step();
      total++;
      if (bus.retired !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", bus.retired); end
   endtask

   task automatic test_async_reset();
      begin_prog();
      exec_to(8'h13);
      total++;
      if (strb !== 5'b10100) begin bad++; $display("FAIL ar_pre_strb got=%b exp=10100", strb); end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (strb !== 5'b00000 || bus.halted !== 1'b0) begin
         bad++; $display("FAIL ar_strobes strb=%b halted=%b exp 00000/0", strb, bus.halted);
      end
      total++;
      if (bus.ir !== 8'h00 || bus.retired !== 8'h00) begin
         bad++; $display("FAIL ar_regs ir=%h retired=%0d exp 00/0", bus.ir, bus.retired);
      end
      bus.start = 1'b0;
      #0.5;
      rst = 1'b0;
      step();
      step();
      total++;
      if (bus.ir !== 8'h00 || strb !== 5'b00000) begin
         bad++; $display("FAIL ar_idle ir=%h strb=%b exp 00/00000", bus.ir, strb);
      end
      bus.start = 1'b1;
      bus.instr_data = 8'h25;
      step();
      step();
      total++;
      if (bus.ir !== 8'h25) begin bad++; $display("FAIL ar_restart_ir got=%h exp=25", bus.ir); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.instr_data = 8'h00;
      bus.zero_flag = 1'b0;
      test_reset();
      test_ldi();
      test_alu();
      test_jump();
      test_nop_range();
      test_halt();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   always @(negedge clk) begin
      if (bus.pc_enable === 1'b1 && bus.pc_load === 1'b1) begin
         $error("pc_enable and pc_load high together");
      end
   end
endmodule
